// File: rtl/smux_pkg.sv
// Shared constants and helpers for the round-robin word multiplexer family.
package smux_pkg;

    localparam int SMUX_WIDTH    = 16;
    localparam int SMUX_CHANNELS = 4;

    typedef enum logic {
        SMUX_EMPTY = 1'b0,
        SMUX_FULL  = 1'b1
    } smux_state_t;

    function automatic int smux_selw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/smux_rr_grant.sv
// Combinational round-robin grant: first valid channel scanning upward from ptr with wrap.
module smux_rr_grant
    import smux_pkg::*;
#(
    parameter  int CHANNELS = SMUX_CHANNELS,
    localparam int SELW     = smux_selw(CHANNELS)
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [SELW-1:0]     ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     grant_idx,
    output logic                any_grant
);

    always_comb begin
        int unsigned w_pos;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_pos     = 0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_pos = 32'(ptr) + k;
            if (w_pos >= CHANNELS) w_pos = w_pos - CHANNELS;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (i == w_pos && !any_grant && valid[i]) begin
                    any_grant = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/smux_rr_arb.sv
// Registered N-way word mux with round-robin arbitration and valid/ready handshakes.
// Optional manual channel select is compiled in with SMUX_FORCE_SEL_EN.
module smux_rr_arb
    import smux_pkg::*;
#(
    parameter  int WIDTH    = SMUX_WIDTH,
    parameter  int CHANNELS = SMUX_CHANNELS,
    localparam int SELW     = smux_selw(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef SMUX_FORCE_SEL_EN
    input  logic                      force_en,
    input  logic [SELW-1:0]           force_sel,
`endif
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [WIDTH*CHANNELS-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready
);

    localparam int unsigned LAST = CHANNELS - 1;

    smux_state_t         r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_data;
    logic [SELW-1:0]     r_chan;
    logic [SELW-1:0]     r_ptr;

    logic [CHANNELS-1:0] w_mask;
    logic                w_force;
    logic [CHANNELS-1:0] w_grant;
    logic [SELW-1:0]     w_gidx;
    logic                w_any;
    logic                w_slot_free;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [WIDTH-1:0]    w_word;

    // Forcing restricts the candidate set to one channel; out-of-range selects leave it empty.
    always_comb begin
        w_mask  = '1;
        w_force = 1'b0;
`ifdef SMUX_FORCE_SEL_EN
        if (force_en) begin
            w_force = 1'b1;
            w_mask  = '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (force_sel == SELW'(i)) w_mask[i] = 1'b1;
            end
        end
`endif
    end

    smux_rr_grant #(.CHANNELS(CHANNELS)) u_grant (
        .valid     (in_valid & w_mask),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .any_grant (w_any)
    );

    assign out_valid   = (r_state == SMUX_FULL);
    assign out_data    = r_data;
    assign out_chan    = r_chan;
    assign w_slot_free = !out_valid || out_ready;
    assign in_ready    = w_grant & {CHANNELS{w_slot_free && !reset}};
    assign w_in_xfer   = w_any && w_slot_free && !reset;
    assign w_out_xfer  = out_valid && out_ready;

    always_comb begin
        w_word = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_gidx == SELW'(i)) w_word = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SMUX_EMPTY: if (w_in_xfer) w_state_nxt = SMUX_FULL;
            SMUX_FULL:  if (w_out_xfer && !w_in_xfer) w_state_nxt = SMUX_EMPTY;
            default:    w_state_nxt = SMUX_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SMUX_EMPTY;
            r_data  <= '0;
            r_chan  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_xfer) begin
                r_data <= w_word;
                r_chan <= w_gidx;
                if (!w_force) begin
                    r_ptr <= (w_gidx == SELW'(LAST)) ? '0 : w_gidx + SELW'(1);
                end
            end
        end
    end

endmodule

// File: doc/smux_rr_arb.md
# smux_rr_arb

Parametrised, registered N-way word multiplexer with a round-robin arbiter and valid/ready handshakes. It generalises the 1-bit, 2-input select mux to WIDTH-bit words across CHANNELS sources. It adds fair arbitration, backpressure and a one-stage output register. It sits between multiple word producers (for example, the CPU data path and I/O ports) and one shared consumer on the Hack-style memory/data bus.

## Interface
- WIDTH, 16: data word width in bits; must be at least 1.
- CHANNELS, 4: number of input channels; must be at least 1.
- SELW, derived: max(1, clog2(CHANNELS)); this is not a user override.
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  in  CHANNELS  per-channel valid; bit i belongs to channel i.
- in_data  in  WIDTH*CHANNELS  flattened words; channel i occupies [i*WIDTH +: WIDTH].
- in_ready  out  CHANNELS  per-channel ready; one-hot or all zero.
- out_valid  out  1  the output register holds a word.
- out_data  out  WIDTH  the registered word.
- out_chan  out  SELW  source channel index of out_data.
- out_ready  in  1  consumer accepts the word when out_valid=1 and out_ready=1.
- force_en  in  1  manual select enable (only with SMUX_FORCE_SEL_EN).
- force_sel  in  SELW  manual channel index (only with SMUX_FORCE_SEL_EN).

## Operation
- A transfer on channel i occurs when in_valid[i]=1 and in_ready[i]=1 in the same cycle. A transfer on the output occurs when out_valid=1 and out_ready=1.
- slot_free = !out_valid || out_ready.
- Grant is combinational: the first channel with valid=1, scanning from ptr upward and wrapping from CHANNELS-1 to 0.
  - in_ready[g] = slot_free for the granted channel g.
  - All other in_ready bits are 0.
  - If no channel is valid, in_ready is all zero.
- On an input transfer:
  - out_data and out_chan load in_data[g] and g.
  - out_valid is set to 1.
  - ptr becomes (g+1) mod CHANNELS.
- When the output transfers and no input transfers in the same cycle, out_valid clears. out_data and out_chan hold their previous values.
- Simultaneous output and input transfer: the new word replaces the old one with no bubble, giving full throughput.
- ptr changes only on an input transfer. Idle cycles do not rotate priority.
- Two-state view:
  - EMPTY (out_valid=0) goes to FULL on an input transfer.
  - FULL goes to EMPTY when the output transfers with no input transfer.
  - FULL stays FULL while out_ready=0 (hold) or on a replace.
- While FULL and out_ready=0, out_data, out_chan and out_valid stay stable. This holds no matter how the inputs change.
- CHANNELS=1: ptr is a constant 0, out_chan is always 0, and the block acts as a one-deep register slice.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0, in_ready=0 during the reset cycle.
- Reset asserted mid-operation discards the held word. No input transfer happens in a cycle where reset=1.
- Latency: a word accepted in cycle n appears with out_valid=1 in cycle n+1.
- Throughput: one word per cycle when out_ready=1.
- in_ready depends combinationally on in_valid, out_valid, out_ready and ptr. in_ready does not depend on in_data.
- out_* are driven from registers only. There is no combinational path from inputs to out_*.

## Configuration
- SMUX_FORCE_SEL_EN defined:
  - Adds the force_en and force_sel ports.
  - When force_en=1, only channel force_sel can be granted, provided it is valid and slot_free=1. Other channels stay stalled.
  - ptr does not change on forced transfers.
  - If force_sel ≥ CHANNELS, nothing is granted.
- SMUX_FORCE_SEL_EN undefined: the ports are absent and the block does pure round-robin.

## Structure
- Package smux_pkg:
  - Default constants SMUX_WIDTH=16 and SMUX_CHANNELS=4.
  - Function smux_selw(n) returning max(1, clog2(n)).
- Sub-module smux_rr_grant:
  - Purely combinational.
  - Inputs: valid vector and ptr. Outputs: one-hot grant, grant index, and any-grant flag.
  - Reused later by the bus arbiter.
- The top level holds ptr, the output register and the handshake logic.

## Test plan
- Reset, then CHANNELS=4 with in_valid=4'b1111, data i=16'h00A0+i and out_ready=1. Required: out_chan sequence 0,1,2,3,0 on consecutive cycles, with out_valid continuously 1 from the first cycle after the first transfer.
- in_valid=4'b1000 only, with ptr=0. Required: channel 3 granted, ptr wraps to 0, and out_data=16'h00A3 one cycle later.
- Output FULL with out_ready=0 for 5 cycles while the inputs change. Required: in_ready=0, out_data and out_chan unchanged. Raising out_ready then drains the word and loads the next one in the same cycle.
- Assert reset while out_valid=1 and out_ready=0. Required: next cycle out_valid=0, out_data=0, out_chan=0, and the next grant starts from channel 0.
- CHANNELS=1, WIDTH=8: stream 8'h01..8'h05 with out_ready toggling every cycle. Required: all five words delivered in order, no loss and no duplicates.
- With SMUX_FORCE_SEL_EN: force_en=1, force_sel=2, all channels valid. Required: only channel 2 is granted and ptr stays unchanged. After force_en=0, round-robin resumes from the prior ptr.
